// File: rtl/register_writeback_pkg.sv
// rtl/register_writeback_pkg.sv - shared types for the writeback merge stage
// Purpose: register-file write port, late-unit input and hazard output types.
`timescale 1ns/1ps
package register_writeback_pkg;

  localparam int XLEN    = 32;
  localparam int REGA_W  = 5;

  // Single write port into the integer register file.
  typedef struct packed {
    logic              wren;
    logic [REGA_W-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } register_write_in_type;

  // Result presented by a long-latency unit.
  typedef struct packed {
    logic              valid;
    logic [REGA_W-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } late_in_type;

  typedef struct packed {
    logic hazard1;
    logic hazard2;
  } hazard_out_type;

  // x0 is hardwired to zero; writes to it are discarded.
  function automatic logic is_x0(input logic [REGA_W-1:0] a);
    return a == '0;
  endfunction

endpackage

// File: rtl/register_writeback_fifo.sv
// rtl/register_writeback_fifo.sv - late-result FIFO for the writeback merge stage
// Purpose: in-order circular buffer of pending late register writes.
// Ports:
//   clk, rst_i                     clock, synchronous active-high reset
//   push_i, push_waddr_i/wdata_i   enqueue one result (ignored when full)
//   pop_i                          dequeue the head (ignored when empty)
//   head_waddr_o, head_wdata_o     oldest pending entry
//   full_o, empty_o                occupancy flags
//   entry_valid_o, entry_waddr_o   per-slot view for the hazard compare
`timescale 1ns/1ps
module writeback_fifo
  import register_writeback_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [REGA_W-1:0]            push_waddr_i,
  input  logic [XLEN-1:0]              push_wdata_i,
  input  logic                         pop_i,
  output logic [REGA_W-1:0]            head_waddr_o,
  output logic [XLEN-1:0]              head_wdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DEPTH-1:0]             entry_valid_o,
  output logic [DEPTH-1:0][REGA_W-1:0] entry_waddr_o
);

  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0][REGA_W-1:0]   waddr_q;
  logic [XLEN-1:0]                wdata_q [DEPTH];
  logic                           do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_waddr_o  = waddr_q[rd_ptr_q];
  assign head_wdata_o  = wdata_q[rd_ptr_q];
  assign entry_valid_o = valid_q;
  assign entry_waddr_o = waddr_q;

  // Pointers are exactly PW bits wide so they wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Push and pop never hit the same slot: equal pointers mean empty (no pop)
  // or full (no push).
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        waddr_q[wr_ptr_q] <= push_waddr_i;
        wdata_q[wr_ptr_q] <= push_wdata_i;
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - merges pipeline and late results onto the register file write port
// Purpose: pipeline commits win the single write port; late results queue in a
// FIFO and drain in idle slots. Pending-write hazards are exported to decode.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pipe_wren/waddr/wdata             in-order pipeline commit
//   late_valid/ready/waddr/wdata      late-unit result handshake
//   raddr1, raddr2 / hazard1, hazard2 decode source compare and stall flags
//   register_win                      registered write port to the register file
`timescale 1ns/1ps
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wren,
  input  logic [REGA_W-1:0]     pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wdata,
  input  logic                  late_valid,
  output logic                  late_ready,
  input  logic [REGA_W-1:0]     late_waddr,
  input  logic [XLEN-1:0]       late_wdata,
  input  logic [REGA_W-1:0]     raddr1,
  input  logic [REGA_W-1:0]     raddr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output register_write_in_type register_win
);

  late_in_type                  late_in;
  hazard_out_type               hz;
  register_write_in_type        out_q, out_d;
  logic                         pipe_eff;
  logic                         late_push;
  logic                         pop_req;
  logic                         fifo_full, fifo_empty;
  logic [REGA_W-1:0]            head_waddr;
  logic [XLEN-1:0]              head_wdata;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REGA_W-1:0] entry_waddr;

  assign late_in    = '{valid: late_valid, waddr: late_waddr, wdata: late_wdata};
  assign late_ready = !rst && !fifo_full;

  // x0 results complete the handshake but are simply not stored.
  assign late_push = late_in.valid && late_ready && !is_x0(late_in.waddr);
  assign pipe_eff  = pipe_wren && !is_x0(pipe_waddr);
  assign pop_req   = !pipe_eff && !fifo_empty;

  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_i         (rst),
    .push_i        (late_push),
    .push_waddr_i  (late_in.waddr),
    .push_wdata_i  (late_in.wdata),
    .pop_i         (pop_req),
    .head_waddr_o  (head_waddr),
    .head_wdata_o  (head_wdata),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_waddr_o (entry_waddr)
  );

  // Idle slots keep waddr/wdata and only drop wren.
  always_comb begin
    out_d      = out_q;
    out_d.wren = 1'b0;
    if (pipe_eff) begin
      out_d = '{wren: 1'b1, waddr: pipe_waddr, wdata: pipe_wdata};
    end else if (pop_req) begin
      out_d = '{wren: 1'b1, waddr: head_waddr, wdata: head_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign register_win = out_q;

  // The output stage counts as pending until its write lands in the file.
  always_comb begin
    hz = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_waddr[i] == raddr1) hz.hazard1 = 1'b1;
      if (entry_valid[i] && entry_waddr[i] == raddr2) hz.hazard2 = 1'b1;
    end
    if (out_q.wren && out_q.waddr == raddr1) hz.hazard1 = 1'b1;
    if (out_q.wren && out_q.waddr == raddr2) hz.hazard2 = 1'b1;
    if (is_x0(raddr1)) hz.hazard1 = 1'b0;
    if (is_x0(raddr2)) hz.hazard2 = 1'b0;
  end

  assign hazard1 = hz.hazard1;
  assign hazard2 = hz.hazard2;

endmodule
